// File: rtl/obj_pixel_serializer.sv
// Sprite-object pixel serializer: loads one 8-pixel, 4-bitplane slice and shifts it out
// one pixel per Cen rising edge, writing opaque pixels into the selected A/B line buffer.
module obj_pixel_serializer #(
    parameter int XW = 9,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Cen,
    input  logic            PLOAD_RSHIFTn,
    input  logic            RL_Sel,
    input  logic            AB_Sel,
    input  logic [31:0]     gfx_data,
    input  logic [CW-1:0]   attr_color,
    input  logic [XW-1:0]   attr_x,
    output logic            lb_we,
    output logic            lb_bank,
    output logic [XW-1:0]   lb_addr,
    output logic [CW+3:0]   lb_data,
    output logic [3:0]      pix,
    output logic            busy
);

    // Slice state
    logic              last_cen_q, last_cen_d;
    logic [3:0][7:0]   planes_q,   planes_d;
    logic [CW-1:0]     colour_q,   colour_d;
    logic [XW-1:0]     x_q,        x_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic              flip_n_q,   flip_n_d;
    logic              bank_q,     bank_d;

    // Registered outputs
    logic              lb_we_q,    lb_we_d;
    logic              lb_bank_q,  lb_bank_d;
    logic [XW-1:0]     lb_addr_q,  lb_addr_d;
    logic [CW+3:0]     lb_data_q,  lb_data_d;
    logic [3:0]        pix_q,      pix_d;
    logic              busy_q,     busy_d;

    logic              evt;
    logic [3:0]        head;

    // A pixel-clock event is the first clk cycle of each Cen high phase.
    assign evt = Cen & ~last_cen_q;

    always_comb begin
        head = '0;
        for (int p = 0; p < 4; p++) begin
            head[p] = flip_n_q ? planes_q[p][7] : planes_q[p][0];
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path through the
        // branches below leaves a variable unassigned and no latch is inferred.
        last_cen_d = Cen;
        planes_d   = planes_q;
        colour_d   = colour_q;
        x_d        = x_q;
        cnt_d      = cnt_q;
        flip_n_d   = flip_n_q;
        bank_d     = bank_q;
        lb_we_d    = 1'b0;
        lb_bank_d  = lb_bank_q;
        lb_addr_d  = lb_addr_q;
        lb_data_d  = lb_data_q;
        pix_d      = pix_q;

        if (evt) begin
            if (!PLOAD_RSHIFTn) begin
                // Load always wins, discarding whatever remains of the previous slice.
                planes_d = gfx_data;
                colour_d = attr_color;
                x_d      = attr_x;
                flip_n_d = RL_Sel;
                bank_d   = AB_Sel;
                cnt_d    = 4'd8;
            end else if (cnt_q != 4'd0) begin
                pix_d = head;
                if (head != 4'd0) begin
                    lb_we_d   = 1'b1;
                    lb_addr_d = x_q;
                    lb_data_d = {colour_q, head};
                    lb_bank_d = bank_q;
                end
                for (int p = 0; p < 4; p++) begin
                    planes_d[p] = flip_n_q ? (planes_q[p] << 1) : (planes_q[p] >> 1);
                end
                // X advances for transparent pixels too and wraps modulo 2^XW.
                x_d   = x_q + XW'(1);
                cnt_d = cnt_q - 4'd1;
            end else begin
                pix_d = 4'd0;
            end
        end

        busy_d = (cnt_d != 4'd0);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples the
        // pre-edge value of the others, matching the hardware.
        if (reset) begin
            // Cen held high across reset release must not look like a rising edge.
            last_cen_q <= 1'b1;
            planes_q   <= '0;
            colour_q   <= '0;
            x_q        <= '0;
            cnt_q      <= '0;
            flip_n_q   <= 1'b0;
            bank_q     <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_bank_q  <= 1'b0;
            lb_addr_q  <= '0;
            lb_data_q  <= '0;
            pix_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            last_cen_q <= last_cen_d;
            planes_q   <= planes_d;
            colour_q   <= colour_d;
            x_q        <= x_d;
            cnt_q      <= cnt_d;
            flip_n_q   <= flip_n_d;
            bank_q     <= bank_d;
            lb_we_q    <= lb_we_d;
            lb_bank_q  <= lb_bank_d;
            lb_addr_q  <= lb_addr_d;
            lb_data_q  <= lb_data_d;
            pix_q      <= pix_d;
            busy_q     <= busy_d;
        end
    end

    assign lb_we   = lb_we_q;
    assign lb_bank = lb_bank_q;
    assign lb_addr = lb_addr_q;
    assign lb_data = lb_data_q;
    assign pix     = pix_q;
    assign busy    = busy_q;

endmodule
